// File: rtl/gray_rd_arbiter.sv
// ---------------------------------------------------------------------------
// gray_rd_arbiter
// Shares the single gray-image memory read port between NREQ pixel engines.
// Round-robin arbitration, at most one read issued per cycle, and read data
// is returned in issue order, tagged (one-hot rvalid) to the requester that
// issued it.
//
// Optional feature macro: GRAY_ARB_LOCK_EN
//   When defined, a requester holding req_lock keeps the port for up to
//   MAX_BURST consecutive grants before being forced to release it for one
//   arbitration. When undefined, req_lock is ignored.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   req        in   [NREQ]     per-requester read request, held until granted
//   req_addr   in   [NREQ*AW]  packed request addresses, requester i at [i*AW +: AW]
//   req_lock   in   [NREQ]     burst lock hint
//   gnt        out  [NREQ]     one-hot combinational grant
//   rvalid     out  [NREQ]     one-hot registered return strobe
//   rdata      out  [DW]       registered returned pixel
//   mem_req    out             registered read strobe to gray memory
//   mem_addr   out  [AW]       registered read address
//   mem_ready  in              memory can accept a read this cycle
//   mem_data   in   [DW]       read data, valid RD_LAT cycles after mem_req
// ---------------------------------------------------------------------------
module gray_rd_arbiter #(
    parameter int NREQ      = 2,
    parameter int AW        = 14,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 mem_req,
    output logic [AW-1:0]        mem_addr,
    input  logic                 mem_ready,
    input  logic [DW-1:0]        mem_data
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            mem_req_q, mem_req_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    // Tag pipe: stage k holds the tag of the grant made k+1 cycles ago, so
    // stage RD_LAT lines up with mem_data for that grant.
    logic [RD_LAT:0] tag_vld_q, tag_vld_d;
    logic [IW-1:0]   tag_idx_q [RD_LAT+1];
    logic [IW-1:0]   tag_idx_d [RD_LAT+1];

    logic            grant_vld;
    logic [IW-1:0]   winner;
    logic [NREQ-1:0] eligible;

`ifdef GRAY_ARB_LOCK_EN
    localparam int BCW = $clog2(MAX_BURST + 1);
    logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
    logic            lock_hold;
    logic            force_rel;
`else
    logic            unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // ---------------- arbitration ----------------
    always_comb begin
        eligible  = req;
        winner    = rr_ptr_q;
        grant_vld = 1'b0;
`ifdef GRAY_ARB_LOCK_EN
        // rr_ptr_q is the previous winner; it may keep the port while locked.
        lock_hold = req[rr_ptr_q] & req_lock[rr_ptr_q]
                    & (burst_cnt_q < BCW'(MAX_BURST - 1));
        force_rel = req[rr_ptr_q] & req_lock[rr_ptr_q]
                    & ~(burst_cnt_q < BCW'(MAX_BURST - 1));
        if (force_rel) begin
            eligible[rr_ptr_q] = 1'b0;
        end
`endif
        // Scan starts one past the last winner and wraps modulo NREQ.
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                winner    = IW'(idx);
            end
        end
`ifdef GRAY_ARB_LOCK_EN
        if (lock_hold) begin
            grant_vld = 1'b1;
            winner    = rr_ptr_q;
        end
`endif
        if (!mem_ready || !reset) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        gnt = '0;
        if (grant_vld) begin
            gnt[winner] = 1'b1;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        rr_ptr_d   = grant_vld ? winner : rr_ptr_q;
        mem_req_d  = grant_vld;
        mem_addr_d = grant_vld ? req_addr[int'(winner)*AW +: AW] : mem_addr_q;

        tag_vld_d[0] = grant_vld;
        tag_idx_d[0] = winner;
        for (int k = 1; k <= RD_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_idx_d[k] = tag_idx_q[k-1];
        end

        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tag_vld_q[RD_LAT]) begin
            rvalid_d[tag_idx_q[RD_LAT]] = 1'b1;
            rdata_d                     = mem_data;
        end
    end

`ifdef GRAY_ARB_LOCK_EN
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (force_rel) begin
            burst_cnt_d = '0;
        end else if (grant_vld) begin
            burst_cnt_d = lock_hold ? burst_cnt_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`endif

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= IW'(NREQ - 1);
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            tag_vld_q  <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_idx_q[k] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            tag_vld_q  <= tag_vld_d;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_idx_q[k] <= tag_idx_d[k];
            end
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gray_rd_arbiter
// Scoreboard bench for gray_rd_arbiter. The driver applies one cycle of
// stimulus, predicts the grant from a round-robin reference model and pushes
// the expected return (requester, pixel, due cycle) into a queue. A separate
// monitor pops and compares whenever rvalid is presented. The memory model
// returns addr[7:0] with RD_LAT cycles of latency.
// ---------------------------------------------------------------------------
module tb_gray_rd_arbiter;

    localparam int NREQ      = 2;
    localparam int AW        = 14;
    localparam int DW        = 8;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 9;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ-1:0]      req_lock = '0;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DW-1:0]        rdata;
    logic                 mem_req;
    logic [AW-1:0]        mem_addr;
    logic                 mem_ready = 1'b1;
    logic [DW-1:0]        mem_data;

    gray_rd_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_lock(req_lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Memory: samples mem_addr at each edge, data emerges RD_LAT cycles later.
    logic [DW-1:0] mem_pipe [RD_LAT];
    always @(posedge clk) begin
        mem_pipe[0] <= DW'(mem_addr[7:0]);
        for (int k = 1; k < RD_LAT; k++) mem_pipe[k] <= mem_pipe[k-1];
    end
    assign mem_data = mem_pipe[RD_LAT-1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        int          idx;
        logic [7:0]  data;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Reference model state.
    int              last_win;
    int              run_len;
    logic            exp_mem_req;
    logic [AW-1:0]   exp_mem_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        last_win     = NREQ - 1;
        run_len      = 1;
        exp_mem_req  = 1'b0;
        exp_mem_addr = '0;
        sb.delete();
    endtask

    // Returns the requester that should win this cycle, or -1, and updates the model.
    function automatic int predict(input logic [NREQ-1:0] r, input logic [NREQ-1:0] lk,
                                   input logic rdy);
        int win;
        bit excluded;
        bit hold;
        win      = -1;
        excluded = 0;
        hold     = 0;
`ifdef GRAY_ARB_LOCK_EN
        if (r[last_win] && lk[last_win]) begin
            if (run_len < MAX_BURST) hold = 1;
            else excluded = 1;
        end
`endif
        if (hold) begin
            win = last_win;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (last_win + k) % NREQ;
                if (win < 0 && r[i] && !(excluded && i == last_win)) win = i;
            end
        end
        if (!rdy) win = -1;
        if (excluded) run_len = 1;
        else if (win >= 0) run_len = hold ? run_len + 1 : 1;
        if (win >= 0) last_win = win;
        return win;
    endfunction

    task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a,
                         input logic [NREQ-1:0] lk, input logic rdy);
        int w;
        logic [NREQ-1:0] eg;
        logic [AW-1:0] wa;
        exp_t e;
        @(posedge clk);
        #1;
        req = r; req_addr = a; req_lock = lk; mem_ready = rdy;
        #1;
        chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
        chk("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
        w  = predict(r, lk, rdy);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        $display("cycle %0d req=%b rdy=%b gnt=%b exp_gnt=%b", cyc, r, rdy, gnt, eg);
        exp_mem_req = (w >= 0);
        if (w >= 0) begin
            wa = a[w*AW +: AW];
            exp_mem_addr = wa;
            e.idx  = w;
            e.data = wa[7:0];
            e.due  = cyc + RD_LAT + 2;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        reset = 1'b0; req = '1; mem_ready = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        model_reset();
        repeat (ncyc) @(posedge clk);
        #1;
        req = '0;
        reset = 1'b1;
    endtask

    function automatic logic [NREQ*AW-1:0] pack2(input int a1, input int a0);
        logic [NREQ*AW-1:0] v;
        v = '0;
        v[0 +: AW]  = AW'(a0);
        v[AW +: AW] = AW'(a1);
        return v;
    endfunction

    function automatic logic [NREQ*AW-1:0] rand_addr();
        logic [NREQ*AW-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*AW +: AW] = AW'($urandom);
        return v;
    endfunction

    // Monitor: compares each presented return against the scoreboard head.
    initial begin
        exp_t e;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (rvalid != '0) begin
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    chk("rvalid", 32'(rvalid), 32'(oh));
                    chk("rdata", 32'(rdata), 32'(e.data));
                    chk("ret_cycle", 32'(cyc), 32'(e.due));
                    $display("return cycle %0d rvalid=%b rdata=%02h exp_rdata=%02h", cyc, rvalid, rdata, e.data);
                end
            end
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("ret_missing", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset with both requesting, then release: first grant goes to 0.
        do_reset(3);
        for (int i = 0; i < 6; i++) cycle(2'b11, pack2(100 + i, 200 + i), 2'b00, 1'b1);
        repeat (3) cycle(2'b00, '0, 2'b00, 1'b1);
        // Single requester back to back, addresses 129, 1, 2.
        cycle(2'b10, pack2(129, 7), 2'b00, 1'b1);
        cycle(2'b10, pack2(1, 7), 2'b00, 1'b1);
        cycle(2'b10, pack2(2, 7), 2'b00, 1'b1);
        repeat (4) cycle(2'b00, '0, 2'b00, 1'b1);
        // mem_ready low blocks grants; in-flight reads complete.
        cycle(2'b11, pack2(33, 44), 2'b00, 1'b1);
        cycle(2'b11, pack2(55, 66), 2'b00, 1'b1);
        repeat (4) cycle(2'b11, pack2(77, 88), 2'b00, 1'b0);
        repeat (2) cycle(2'b11, pack2(91, 92), 2'b00, 1'b1);
        repeat (4) cycle(2'b00, '0, 2'b00, 1'b1);
        // Reset while reads are in flight: nothing may return.
        cycle(2'b01, pack2(0, 17), 2'b00, 1'b1);
        cycle(2'b01, pack2(0, 18), 2'b00, 1'b1);
        do_reset(1);
        repeat (5) cycle(2'b00, '0, 2'b00, 1'b1);
        cycle(2'b11, pack2(21, 22), 2'b00, 1'b1);
        repeat (4) cycle(2'b00, '0, 2'b00, 1'b1);
        // Lock on requester 0.
        for (int i = 0; i < 24; i++) cycle(2'b11, pack2(300 + i, 400 + i), 2'b01, 1'b1);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(NREQ'($urandom), rand_addr(), NREQ'($urandom),
                  ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0);
        end
        repeat (RD_LAT + 6) cycle(2'b00, '0, 2'b00, 1'b1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
